// File: rtl/rev_gpio_dbnc_pkg.sv
// Register offsets and access-error decode shared by the GPIO block.
package rev_gpio_pkg;

  localparam logic [7:0] OFF_MODE      = 8'h00;
  localparam logic [7:0] OFF_DIR       = 8'h04;
  localparam logic [7:0] OFF_OUT       = 8'h08;
  localparam logic [7:0] OFF_IN        = 8'h0C;
  localparam logic [7:0] OFF_TR_TYPE   = 8'h10;
  localparam logic [7:0] OFF_TR_LVL0   = 8'h14;
  localparam logic [7:0] OFF_TR_LVL1   = 8'h18;
  localparam logic [7:0] OFF_TR_STAT   = 8'h1C;
  localparam logic [7:0] OFF_IRQ_EN    = 8'h20;
  localparam logic [7:0] OFF_OUT_SET   = 8'h24;
  localparam logic [7:0] OFF_OUT_CLR   = 8'h28;
  localparam logic [7:0] OFF_OUT_TGL   = 8'h2C;
  localparam logic [7:0] OFF_DBNC_EN   = 8'h30;
  localparam logic [7:0] OFF_DBNC_LOAD = 8'h34;

  // hi_nz flags any set address bit above the 8-bit offset window.
  function automatic logic addr_err(input logic [7:0] off, input logic hi_nz,
                                    input logic wr);
    logic e;
    e = hi_nz || (off[1:0] != 2'b00) || (off > OFF_DBNC_LOAD);
    if (wr && (off == OFF_IN)) e = 1'b1;
    if (!wr && ((off == OFF_OUT_SET) || (off == OFF_OUT_CLR) || (off == OFF_OUT_TGL)))
      e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/rev_gpio_dbnc_if.sv
// APB slave bundle for the GPIO block.
interface rev_gpio_dbnc_if #(
  parameter int GPIO_PINS  = 32,
  parameter int PADDR_SIZE = 20
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [PADDR_SIZE-1:0]   paddr;
  logic [GPIO_PINS-1:0]    pwdata;
  logic [GPIO_PINS/8-1:0]  pstrb;
  logic                    pready;
  logic [GPIO_PINS-1:0]    prdata;
  logic                    pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  pready, prdata, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/rev_gpio_filter.sv
// One pin: synchroniser, optional debounce (REV_GPIO_DBNC_EN), filt and filt_d.
module rev_gpio_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_W      = 16
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              pad,
  input  logic              en,
  input  logic [DBNC_W-1:0] d,
  output logic              filt,
  output logic              filt_d
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end
  assign sync = sync_q[SYNC_STAGES-1];

`ifdef REV_GPIO_DBNC_EN
  logic [DBNC_W-1:0] cnt;

  // cnt >= d so that lowering d below a running count releases on the next mismatch
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (!en) begin
      filt <= sync;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (cnt >= d) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{en, d};

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) filt <= 1'b0;
    else        filt <= sync;
  end
`endif

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) filt_d <= 1'b0;
    else        filt_d <= filt;
  end

endmodule

// File: rtl/rev_gpio_dbnc.sv
// APB GPIO with per-pin sync/debounce, atomic output ops and level/edge interrupts.
// Debounce counters and DBNC_EN/DBNC_LOAD are built only when REV_GPIO_DBNC_EN is defined.
module rev_gpio_dbnc
  import rev_gpio_pkg::*;
#(
  parameter int GPIO_PINS   = 32,
  parameter int PADDR_SIZE  = 20,
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_W      = 16
) (
  input  logic                 pclk,
  input  logic                 prstn,
  rev_gpio_dbnc_if.slave       apb,
  input  logic [GPIO_PINS-1:0] gpio_i,
  output logic [GPIO_PINS-1:0] gpio_o,
  output logic [GPIO_PINS-1:0] gpio_oe,
  output logic                 irq_o
);

  logic [7:0]           off;
  logic                 access, err, wr, rd;
  logic [GPIO_PINS-1:0] bm, wd, w1c, prdata_c;
  logic [GPIO_PINS-1:0] reg_mode, reg_dir, reg_out, reg_tr_type;
  logic [GPIO_PINS-1:0] reg_lvl0, reg_lvl1, reg_stat, reg_irq_en;
  logic [GPIO_PINS-1:0] dbnc_en;
  logic [DBNC_W-1:0]    dbnc_load;
  logic [GPIO_PINS-1:0] filt, filt_d, rise, fall, hit;

  assign off    = apb.paddr[7:0];
  assign access = apb.psel & apb.penable;
  assign err    = access & addr_err(off, |apb.paddr[PADDR_SIZE-1:8], apb.pwrite);
  assign wr     = access &  apb.pwrite & ~err;
  assign rd     = access & ~apb.pwrite & ~err;

  always_comb begin
    bm = '0;
    for (int i = 0; i < GPIO_PINS; i++) bm[i] = apb.pstrb[i/8];
  end
  assign wd  = apb.pwdata & bm;
  assign w1c = (wr && (off == OFF_TR_STAT)) ? wd : '0;

  for (genvar g = 0; g < GPIO_PINS; g++) begin : g_pin
    rev_gpio_filter #(.SYNC_STAGES(SYNC_STAGES), .DBNC_W(DBNC_W)) u_filt (
      .pclk   (pclk),
      .prstn  (prstn),
      .pad    (gpio_i[g]),
      .en     (dbnc_en[g]),
      .d      (dbnc_load),
      .filt   (filt[g]),
      .filt_d (filt_d[g])
    );
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;
  assign hit  = (~reg_tr_type & ((reg_lvl0 & ~filt) | (reg_lvl1 & filt))) |
                ( reg_tr_type & ((reg_lvl0 & fall)  | (reg_lvl1 & rise)));

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      reg_mode    <= '0;
      reg_dir     <= '0;
      reg_out     <= '0;
      reg_tr_type <= '0;
      reg_lvl0    <= '0;
      reg_lvl1    <= '0;
      reg_irq_en  <= '0;
`ifdef REV_GPIO_DBNC_EN
      dbnc_en     <= '0;
      dbnc_load   <= '0;
`endif
    end else if (wr) begin
      case (off)
        OFF_MODE:    reg_mode    <= (reg_mode    & ~bm) | wd;
        OFF_DIR:     reg_dir     <= (reg_dir     & ~bm) | wd;
        OFF_OUT:     reg_out     <= (reg_out     & ~bm) | wd;
        OFF_TR_TYPE: reg_tr_type <= (reg_tr_type & ~bm) | wd;
        OFF_TR_LVL0: reg_lvl0    <= (reg_lvl0    & ~bm) | wd;
        OFF_TR_LVL1: reg_lvl1    <= (reg_lvl1    & ~bm) | wd;
        OFF_IRQ_EN:  reg_irq_en  <= (reg_irq_en  & ~bm) | wd;
        OFF_OUT_SET: reg_out     <= reg_out | wd;
        OFF_OUT_CLR: reg_out     <= reg_out & ~wd;
        OFF_OUT_TGL: reg_out     <= reg_out ^ wd;
`ifdef REV_GPIO_DBNC_EN
        OFF_DBNC_EN:   dbnc_en   <= (dbnc_en & ~bm) | wd;
        OFF_DBNC_LOAD: dbnc_load <= (dbnc_load & ~bm[DBNC_W-1:0]) | wd[DBNC_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Hardware set wins over a same-cycle W1C; pad outputs and irq are registered.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      reg_stat <= '0;
      irq_o    <= 1'b0;
      gpio_o   <= '0;
      gpio_oe  <= '0;
    end else begin
      reg_stat <= (reg_stat & ~w1c) | hit;
      irq_o    <= |(reg_stat & reg_irq_en);
      gpio_o   <= reg_out & ~reg_mode;
      gpio_oe  <= reg_dir & (~reg_mode | ~reg_out);
    end
  end

`ifdef REV_GPIO_DBNC_EN
  logic [GPIO_PINS-1:0] load_ext;
  always_comb begin
    load_ext = '0;
    load_ext[DBNC_W-1:0] = dbnc_load;
  end
`else
  assign dbnc_en   = '0;
  assign dbnc_load = '0;
`endif

  always_comb begin
    prdata_c = '0;
    if (rd) begin
      case (off)
        OFF_MODE:    prdata_c = reg_mode;
        OFF_DIR:     prdata_c = reg_dir;
        OFF_OUT:     prdata_c = reg_out;
        OFF_IN:      prdata_c = filt;
        OFF_TR_TYPE: prdata_c = reg_tr_type;
        OFF_TR_LVL0: prdata_c = reg_lvl0;
        OFF_TR_LVL1: prdata_c = reg_lvl1;
        OFF_TR_STAT: prdata_c = reg_stat;
        OFF_IRQ_EN:  prdata_c = reg_irq_en;
`ifdef REV_GPIO_DBNC_EN
        OFF_DBNC_EN:   prdata_c = dbnc_en;
        OFF_DBNC_LOAD: prdata_c = load_ext;
`endif
        default:     prdata_c = '0;
      endcase
    end
  end

  assign apb.prdata  = prdata_c;
  assign apb.pslverr = err;
  assign apb.pready  = 1'b1;

endmodule

// File: tb/tb_rev_gpio_dbnc.sv
// Scoreboard bench for rev_gpio_dbnc: stimulus queues expectations, a negedge monitor checks them.
module tb_rev_gpio_dbnc;

`ifdef REV_GPIO_DBNC_EN
  localparam bit HAS_DBNC = 1'b1;
`else
  localparam bit HAS_DBNC = 1'b0;
`endif
  localparam int D_EFF = HAS_DBNC ? 4 : 0;
  localparam int LAT   = 2 + 1 + D_EFF;

  localparam logic [19:0] A_MODE = 20'h00, A_DIR = 20'h04, A_OUT = 20'h08, A_IN = 20'h0C;
  localparam logic [19:0] A_TYPE = 20'h10, A_LVL0 = 20'h14, A_LVL1 = 20'h18, A_STAT = 20'h1C;
  localparam logic [19:0] A_IEN = 20'h20, A_SET = 20'h24, A_CLR = 20'h28, A_TGL = 20'h2C;
  localparam logic [19:0] A_DEN = 20'h30, A_DLD = 20'h34, A_BAD = 20'h3C;

  logic        pclk = 1'b0;
  logic        prstn;
  logic [31:0] gpio_i, gpio_o, gpio_oe;
  logic        irq_o;

  always #5 pclk = ~pclk;

  rev_gpio_dbnc_if #(.GPIO_PINS(32), .PADDR_SIZE(20)) apb ();

  rev_gpio_dbnc #(.GPIO_PINS(32), .PADDR_SIZE(20), .SYNC_STAGES(2), .DBNC_W(16)) dut (
    .pclk    (pclk),
    .prstn   (prstn),
    .apb     (apb),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq_o   (irq_o)
  );

  typedef enum int {K_APB, K_GO, K_GOE, K_IRQ} kind_t;
  typedef struct {
    kind_t       kind;
    string       name;
    logic [31:0] val;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  logic probe_req = 1'b0;

  always @(negedge pclk) begin
    exp_t        e;
    logic [31:0] act;
    logic        aerr;
    if ((apb.psel && apb.penable) || probe_req) begin
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_output: nothing queued at %0t", $time);
      end else begin
        e    = q.pop_front();
        aerr = 1'b0;
        case (e.kind)
          K_APB:   begin act = apb.prdata; aerr = apb.pslverr; end
          K_GO:    act = gpio_o;
          K_GOE:   act = gpio_oe;
          K_IRQ:   act = {31'b0, irq_o};
          default: act = '0;
        endcase
        nvec++;
        if (act !== e.val || aerr !== e.err || apb.pready !== 1'b1) begin
          nerr++;
          $display("FAIL %s: got data=%h err=%b ready=%b, want data=%h err=%b ready=1",
                   e.name, act, aerr, apb.pready, e.val, e.err);
        end
      end
    end
  end

  // Called just after a rising edge; the access phase is sampled after the next edge.
  task automatic apb_acc(input logic wr, input logic [19:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [31:0] exp_rd,
                         input logic exp_err, input string name);
    exp_t e;
    e.kind = K_APB; e.name = name; e.val = exp_rd; e.err = exp_err;
    q.push_back(e);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = addr; apb.pwdata = data; apb.pstrb = strb;
    @(posedge pclk); #1 apb.penable = 1'b1;
    @(posedge pclk); #1 apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic wr_reg(input logic [19:0] addr, input logic [31:0] data, input string name);
    apb_acc(1'b1, addr, data, 4'hF, 32'h0, 1'b0, name);
  endtask

  task automatic rd_reg(input logic [19:0] addr, input logic [31:0] exp_v, input string name);
    apb_acc(1'b0, addr, 32'h0, 4'h0, exp_v, 1'b0, name);
  endtask

  // Samples at the next falling edge, returns just after the following rising edge.
  task automatic probe(input kind_t k, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = k; e.name = name; e.val = v; e.err = 1'b0;
    q.push_back(e);
    probe_req = 1'b1;
    @(negedge pclk); #1 probe_req = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    prstn = 1'b0; gpio_i = '0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
    #1;
    probe(K_GO,  32'h0, "rst_gpio_o");
    probe(K_GOE, 32'h0, "rst_gpio_oe");
    probe(K_IRQ, 32'h0, "rst_irq");
    prstn = 1'b1;
    idle(2);
    rd_reg(A_OUT,  32'h0, "rst_out");
    rd_reg(A_STAT, 32'h0, "rst_stat");
    rd_reg(A_DLD,  32'h0, "rst_dbnc_load");

    // atomic set/clear/toggle, full strobes then byte 1 only
    wr_reg(A_SET, 32'h0000_00F0, "set_f0");
    wr_reg(A_CLR, 32'h0000_0030, "clr_30");
    wr_reg(A_TGL, 32'h0000_0101, "tgl_101");
    rd_reg(A_OUT, 32'h0000_01C1, "out_atomic");
    apb_acc(1'b1, A_SET, 32'h0000_00F0, 4'h2, 32'h0, 1'b0, "set_f0_s2");
    apb_acc(1'b1, A_CLR, 32'h0000_0030, 4'h2, 32'h0, 1'b0, "clr_30_s2");
    apb_acc(1'b1, A_TGL, 32'h0000_0101, 4'h2, 32'h0, 1'b0, "tgl_101_s2");
    rd_reg(A_OUT, 32'h0000_00C1, "out_strb_tgl");
    apb_acc(1'b1, A_SET, 32'hFFFF_FFFF, 4'h2, 32'h0, 1'b0, "set_all_s2");
    rd_reg(A_OUT, 32'h0000_FFC1, "out_strb_set");

    // error responses
    apb_acc(1'b0, A_SET, 32'h0, 4'h0, 32'h0, 1'b1, "rd_out_set_err");
    apb_acc(1'b0, A_TGL, 32'h0, 4'h0, 32'h0, 1'b1, "rd_out_tgl_err");
    apb_acc(1'b1, A_BAD, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_unmapped_err");
    apb_acc(1'b1, A_IN,  32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_in_err");
    apb_acc(1'b0, A_BAD, 32'h0, 4'h0, 32'h0, 1'b1, "rd_unmapped_err");
    rd_reg(A_OUT,  32'h0000_FFC1, "errwr_out_kept");
    rd_reg(A_MODE, 32'h0, "errwr_mode_kept");

    // open-drain on pin 3
    wr_reg(A_DIR,  32'h8, "dir_p3");
    wr_reg(A_MODE, 32'h8, "mode_p3");
    idle(1);
    probe(K_GOE, 32'h0000_0008, "oe_od_low");
    probe(K_GO,  32'h0000_FFC1, "o_od_forced0");
    wr_reg(A_SET, 32'h8, "set_p3");
    probe(K_GOE, 32'h0000_0008, "oe_one_edge");
    probe(K_GOE, 32'h0000_0000, "oe_od_release");

    // debounce on pin 0
    wr_reg(A_DEN, 32'h1, "dbnc_en_p0");
    wr_reg(A_DLD, 32'h4, "dbnc_load_4");
    rd_reg(A_DLD, HAS_DBNC ? 32'h4 : 32'h0, "dbnc_load_rd");
    rd_reg(A_DEN, HAS_DBNC ? 32'h1 : 32'h0, "dbnc_en_rd");
    gpio_i[0] = 1'b1;
    idle(4);
    gpio_i[0] = 1'b0;
    idle(10);
    rd_reg(A_IN, 32'h0, "in_short_pulse");
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= 7; k += 2)
      rd_reg(A_IN, (k >= LAT) ? 32'h1 : 32'h0, $sformatf("in_rise_e%0d", k));
    gpio_i[0] = 1'b0;
    idle(12);
    gpio_i[0] = 1'b1;
    idle(1);
    for (int k = 2; k <= 8; k += 2)
      rd_reg(A_IN, (k >= LAT) ? 32'h1 : 32'h0, $sformatf("in_rise2_e%0d", k));

    // rising-edge interrupt on pin 5
    wr_reg(A_TYPE, 32'h20, "type_p5_edge");
    wr_reg(A_LVL1, 32'h20, "lvl1_p5");
    wr_reg(A_IEN,  32'h20, "ien_p5");
    gpio_i[5] = 1'b1;
    idle(3);
    probe(K_IRQ, 32'h0, "irq_e3");
    probe(K_IRQ, 32'h0, "irq_e4");
    probe(K_IRQ, 32'h1, "irq_e5");
    rd_reg(A_STAT, 32'h20, "edge_stat");
    wr_reg(A_STAT, 32'h20, "w1c_p5");
    probe(K_IRQ, 32'h1, "irq_after_w1c_edge");
    probe(K_IRQ, 32'h0, "irq_cleared");
    rd_reg(A_STAT, 32'h0, "edge_stat_clr");

    // level hit on pin 2 beats a same-cycle W1C
    wr_reg(A_LVL0, 32'h4, "lvl0_p2");
    idle(2);
    wr_reg(A_STAT, 32'h4, "w1c_p2");
    rd_reg(A_STAT, 32'h4, "lvl_w1c_collide");
    probe(K_IRQ, 32'h0, "irq_masked_p2");
    wr_reg(A_LVL0, 32'h0, "lvl0_off");
    wr_reg(A_STAT, 32'h4, "w1c_p2_again");
    rd_reg(A_STAT, 32'h0, "lvl_stat_clr");

    // asynchronous reset during a debounce count
    wr_reg(A_LVL0, 32'h4, "lvl0_p2_on");
    wr_reg(A_IEN,  32'h24, "ien_p2_p5");
    idle(2);
    probe(K_IRQ, 32'h1, "irq_lvl_p2");
    gpio_i[0] = 1'b0;
    idle(4);
    prstn  = 1'b0;
    gpio_i = 32'hFFFF_FFFF;
    probe(K_GO,  32'h0, "rst_async_o");
    probe(K_GOE, 32'h0, "rst_async_oe");
    probe(K_IRQ, 32'h0, "rst_async_irq");
    prstn = 1'b1;
    idle(10);
    rd_reg(A_STAT, 32'h0, "post_rst_stat");
    rd_reg(A_IN,   32'hFFFF_FFFF, "post_rst_in");
    rd_reg(A_OUT,  32'h0, "post_rst_out");
    rd_reg(A_DEN,  32'h0, "post_rst_dbnc_en");
    probe(K_IRQ, 32'h0, "post_rst_irq");

    idle(2);
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL pending_expectations: %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
